// File: rtl/main_pkg.sv
// Shared constants for the FT245 loopback-test core: FSM encoding, default strobe widths
// and the byte-sequence helper used by both the tx counter and the rx checker.
package main_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RD_STROBE  = 3'd1;
  localparam logic [2:0] ST_RD_RECOVER = 3'd2;
  localparam logic [2:0] ST_WR_SETUP   = 3'd3;
  localparam logic [2:0] ST_WR_STROBE  = 3'd4;
  localparam logic [2:0] ST_WR_HOLD    = 3'd5;

  localparam int DEF_RD_LOW_CYCLES = 3;
  localparam int DEF_WR_LOW_CYCLES = 3;
  localparam int DEF_STALL_LIMIT   = 16777216;
  localparam int STALL_W           = 24;
  localparam int CNT_W             = 8;

  function automatic logic [7:0] seq_next(input logic [7:0] b);
    return b + 8'd1;
  endfunction

endpackage

// File: rtl/main_pll.sv
// 12 MHz -> 36 MHz core clock generator. Behavioural stand-in passes the reference through;
// the vendor PLL primitive replaces the body on hardware.
module main_pll (
  input  logic ref_clk,
  output logic clock_out
);

  assign clock_out = ref_clk;

endmodule

// File: rtl/main.sv
// FT245 asynchronous FIFO exerciser: reads host bytes and checks they form an incrementing
// sequence, writes an incrementing byte stream, and latches rx-sequence / tx-stall errors on LEDs.
module main
  import main_pkg::*;
#(
  parameter int RD_LOW_CYCLES = DEF_RD_LOW_CYCLES,
  parameter int WR_LOW_CYCLES = DEF_WR_LOW_CYCLES,
  parameter int STALL_LIMIT   = DEF_STALL_LIMIT
) (
  input  logic pin_clk_i,
  input  logic reset_i,
  inout  wire  fifo_d0_io,
  inout  wire  fifo_d1_io,
  inout  wire  fifo_d2_io,
  inout  wire  fifo_d3_io,
  inout  wire  fifo_d4_io,
  inout  wire  fifo_d5_io,
  inout  wire  fifo_d6_io,
  inout  wire  fifo_d7_io,
  input  logic fifo_nRXF_i,
  input  logic fifo_nTXE_i,
  output logic fifo_nRD_o,
  output logic fifo_nWD_o,
  output logic led_rxerr_o,
  output logic led_txerr_o
);

  localparam logic [CNT_W-1:0]   RD_LAST    = CNT_W'(RD_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WR_LAST    = CNT_W'(WR_LOW_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

  logic clk;

  main_pll pll_36mh (
    .ref_clk   (pin_clk_i),
    .clock_out (clk)
  );

  logic             nrxf_p0, nrxf_p1, ntxe_p0, ntxe_p1;
  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             last_wr, last_wr_nx;
  logic             nrd, nwd, drive;
  logic [7:0]       tx_byte, rx_ref, bus_in;
  logic             rx_first, rx_err, tx_err;
  logic [STALL_W-1:0] stall_cnt;
  logic             rd_req, wr_req, pick_rd, pick_wr, arb, sample, tx_done;

  assign bus_in = {fifo_d7_io, fifo_d6_io, fifo_d5_io, fifo_d4_io,
                   fifo_d3_io, fifo_d2_io, fifo_d1_io, fifo_d0_io};

  // stage p0/p1: two-flop synchronizers on the FIFO status flags
  always_ff @(posedge clk) begin
    if (reset_i) begin
      nrxf_p0 <= 1'b1;
      nrxf_p1 <= 1'b1;
      ntxe_p0 <= 1'b1;
      ntxe_p1 <= 1'b1;
    end else begin
      nrxf_p0 <= fifo_nRXF_i;
      nrxf_p1 <= nrxf_p0;
      ntxe_p0 <= fifo_nTXE_i;
      ntxe_p1 <= ntxe_p0;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    last_wr_nx = last_wr;
    sample     = 1'b0;
    tx_done    = 1'b0;
    arb        = 1'b0;
    rd_req     = !nrxf_p1;
    wr_req     = !ntxe_p1;
    pick_rd    = rd_req && (!wr_req || last_wr);
    pick_wr    = wr_req && (!rd_req || !last_wr);
    case (state)
      ST_IDLE:       arb = 1'b1;
      ST_RD_STROBE: begin
        if (cnt == RD_LAST) begin
          sample   = 1'b1;
          state_nx = ST_RD_RECOVER;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      // the recovery exit arbitrates directly so back-to-back reads see only the 2 high cycles
      ST_RD_RECOVER: begin
        if (cnt == CNT_W'(1)) arb = 1'b1;
        else                  cnt_nx = cnt + 1'b1;
      end
      ST_WR_SETUP: begin
        state_nx = ST_WR_STROBE;
        cnt_nx   = '0;
      end
      ST_WR_STROBE: begin
        if (cnt == WR_LAST) state_nx = ST_WR_HOLD;
        else                cnt_nx   = cnt + 1'b1;
      end
      ST_WR_HOLD: begin
        tx_done  = 1'b1;
        state_nx = ST_IDLE;
      end
      default:       state_nx = ST_IDLE;
    endcase
    if (arb) begin
      state_nx = ST_IDLE;
      if (pick_rd) begin
        state_nx   = ST_RD_STROBE;
        cnt_nx     = '0;
        last_wr_nx = 1'b0;
      end else if (pick_wr) begin
        state_nx   = ST_WR_SETUP;
        last_wr_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last_wr  <= 1'b1;
      nrd      <= 1'b1;
      nwd      <= 1'b1;
      drive    <= 1'b0;
      tx_byte  <= 8'h00;
      rx_first <= 1'b1;
      rx_err   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      last_wr <= last_wr_nx;
      nrd     <= (state_nx != ST_RD_STROBE);
      nwd     <= (state_nx != ST_WR_STROBE);
      drive   <= (state_nx == ST_WR_SETUP) || (state_nx == ST_WR_STROBE) ||
                 (state_nx == ST_WR_HOLD);
      if (tx_done) tx_byte <= seq_next(tx_byte);
      if (sample) begin
        rx_first <= 1'b0;
        if (!rx_first && (bus_in != seq_next(rx_ref))) rx_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample) rx_ref <= bus_in;
  end

  // counter saturates, so a limit of 2^24 still fits the 24-bit compare
  always_ff @(posedge clk) begin
    if (reset_i) begin
      stall_cnt <= '0;
      tx_err    <= 1'b0;
    end else if (!ntxe_p1) begin
      stall_cnt <= '0;
    end else begin
      if (stall_cnt != '1)         stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == STALL_LAST) tx_err    <= 1'b1;
    end
  end

  assign fifo_d0_io  = drive ? tx_byte[0] : 1'bz;
  assign fifo_d1_io  = drive ? tx_byte[1] : 1'bz;
  assign fifo_d2_io  = drive ? tx_byte[2] : 1'bz;
  assign fifo_d3_io  = drive ? tx_byte[3] : 1'bz;
  assign fifo_d4_io  = drive ? tx_byte[4] : 1'bz;
  assign fifo_d5_io  = drive ? tx_byte[5] : 1'bz;
  assign fifo_d6_io  = drive ? tx_byte[6] : 1'bz;
  assign fifo_d7_io  = drive ? tx_byte[7] : 1'bz;
  assign fifo_nRD_o  = nrd;
  assign fifo_nWD_o  = nwd;
  assign led_rxerr_o = rx_err;
  assign led_txerr_o = tx_err;

endmodule

// File: tb/tb_main.sv
// Directed bench for main: an FT245 host model with a pulled-up bus, a strobe/byte monitor,
// and a linear sequence of read, write, arbitration, stall and reset scenarios.
module tb_main;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic nrxf  = 1'b1;
  logic ntxe  = 1'b1;
  wire  d0, d1, d2, d3, d4, d5, d6, d7;
  wire  nrd, nwd, rxerr, txerr;
  wire  [7:0] bus = {d7, d6, d5, d4, d3, d2, d1, d0};

  logic [7:0] rx_seq [0:15];
  logic [3:0] rd_count = 4'd0;
  logic [7:0] host_byte;
  assign host_byte = rx_seq[rd_count];

  pullup pu0 (d0);
  pullup pu1 (d1);
  pullup pu2 (d2);
  pullup pu3 (d3);
  pullup pu4 (d4);
  pullup pu5 (d5);
  pullup pu6 (d6);
  pullup pu7 (d7);

  // host puts the next byte on the bus while the read strobe is low
  assign d0 = !nrd ? host_byte[0] : 1'bz;
  assign d1 = !nrd ? host_byte[1] : 1'bz;
  assign d2 = !nrd ? host_byte[2] : 1'bz;
  assign d3 = !nrd ? host_byte[3] : 1'bz;
  assign d4 = !nrd ? host_byte[4] : 1'bz;
  assign d5 = !nrd ? host_byte[5] : 1'bz;
  assign d6 = !nrd ? host_byte[6] : 1'bz;
  assign d7 = !nrd ? host_byte[7] : 1'bz;

  main #(.STALL_LIMIT(100)) dut (
    .pin_clk_i   (clk),
    .reset_i     (reset),
    .fifo_d0_io  (d0),
    .fifo_d1_io  (d1),
    .fifo_d2_io  (d2),
    .fifo_d3_io  (d3),
    .fifo_d4_io  (d4),
    .fifo_d5_io  (d5),
    .fifo_d6_io  (d6),
    .fifo_d7_io  (d7),
    .fifo_nRXF_i (nrxf),
    .fifo_nTXE_i (ntxe),
    .fifo_nRD_o  (nrd),
    .fifo_nWD_o  (nwd),
    .led_rxerr_o (rxerr),
    .led_txerr_o (txerr)
  );

  logic       prev_nrd = 1'b1, prev_nwd = 1'b1;
  logic [9:0] wr_count = 10'd0;
  logic [7:0] wr_cur = 8'h00;
  logic [7:0] wr_log [0:1023];
  logic [7:0] op_count = 8'd0;
  logic       op_log [0:255];
  int         overlap = 0;

  always @(negedge clk) begin
    prev_nrd <= nrd;
    prev_nwd <= nwd;
    if (!nwd) wr_cur <= bus;
    if (!prev_nwd && nwd) begin
      wr_log[wr_count] <= wr_cur;
      wr_count <= wr_count + 10'd1;
    end
    if (!prev_nrd && nrd) rd_count <= rd_count + 4'd1;
    if (prev_nrd && !nrd) begin
      op_log[op_count] <= 1'b0;
      op_count <= op_count + 8'd1;
    end
    if (prev_nwd && !nwd) begin
      op_log[op_count] <= 1'b1;
      op_count <= op_count + 8'd1;
    end
    if (!reset && !nrd && !nwd) overlap <= overlap + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_level(input bit sel_wr, input logic lvl, output bit ok);
    int i = 0;
    while (((sel_wr ? nwd : nrd) !== lvl) && i < 300) begin
      @(negedge clk);
      i++;
    end
    ok = ((sel_wr ? nwd : nrd) === lvl);
  endtask

  task automatic run_width(input bit sel_wr, input logic lvl, output int w);
    w = 0;
    while (((sel_wr ? nwd : nrd) === lvl) && w < 50) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic wait_reads(input logic [3:0] target, output bit ok);
    int i = 0;
    while (rd_count != target && i < 300) begin
      @(negedge clk);
      i++;
    end
    ok = (rd_count == target);
  endtask

  task automatic wait_writes(input logic [9:0] target, input int budget, output bit ok);
    int i = 0;
    while (wr_count != target && i < budget) begin
      @(negedge clk);
      i++;
    end
    ok = (wr_count == target);
  endtask

  initial begin
    bit         ok;
    int         w;
    bit         stay;
    logic [3:0] rb;
    logic [9:0] wb;
    logic [7:0] ob;
    logic [7:0] exp;
    int         ov0;

    // reset values while reset is held
    cyc(3);
    check("rst_nrd", nrd, 1);
    check("rst_nwd", nwd, 1);
    check("rst_bus_hiz", bus, 8'hFF);
    check("rst_rxerr", rxerr, 0);
    check("rst_txerr", txerr, 0);

    // three clean reads: 3-cycle strobes with 2-cycle gaps
    rb = rd_count;
    for (int k = 0; k < 16; k++) rx_seq[rb + 4'(k)] = 8'h10 + 8'(k);
    reset = 1'b0;
    nrxf  = 1'b0;
    wait_level(0, 1'b0, ok);
    check("rd_start", ok, 1);
    for (int p = 0; p < 3; p++) begin
      run_width(0, 1'b0, w);
      check("rd_width", w, 3);
      if (p < 2) begin
        run_width(0, 1'b1, w);
        check("rd_gap", w, 2);
      end
    end
    nrxf = 1'b1;
    cyc(20);
    check("rd_seq_ok_rxerr", rxerr, 0);
    check("rd_only_nwd_idle", nwd, 1);

    // sequence break 0x10 -> 0x13 latches the rx error
    reset = 1'b1;
    cyc(2);
    rb = rd_count;
    rx_seq[rb] = 8'h10;
    for (int k = 1; k < 16; k++) rx_seq[rb + 4'(k)] = 8'h12 + 8'(k);
    reset = 1'b0;
    nrxf  = 1'b0;
    wait_reads(rb + 4'd1, ok);
    check("rxerr_first_read_ok", ok, 1);
    check("rxerr_after_first", rxerr, 0);
    wait_reads(rb + 4'd2, ok);
    check("rxerr_second_read_ok", ok, 1);
    check("rxerr_after_second", rxerr, 1);
    nrxf = 1'b1;
    cyc(30);
    check("rxerr_sticky", rxerr, 1);
    reset = 1'b1;
    cyc(2);
    check("rxerr_cleared_by_reset", rxerr, 0);

    // writes: setup / strobe / hold framing and released bus between writes
    wb = wr_count;
    reset = 1'b0;
    ntxe  = 1'b0;
    for (int p = 0; p < 3; p++) begin
      exp = 8'(p);
      w = 0;
      while (bus !== exp && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("wr_setup_byte", bus, exp);
      check("wr_setup_nwd_high", nwd, 1);
      cyc(1);
      w = 0;
      stay = 1'b1;
      while (nwd === 1'b0 && w < 50) begin
        if (bus !== exp) stay = 1'b0;
        @(negedge clk);
        w++;
      end
      check("wr_strobe_width", w, 3);
      check("wr_strobe_byte_held", stay, 1);
      check("wr_hold_byte", bus, exp);
      cyc(1);
      check("wr_released", bus, 8'hFF);
    end
    wait_writes(wb + 10'd257, 2500, ok);
    check("wr_257_done", ok, 1);
    check("wr_byte_2", wr_log[wb + 10'd2], 8'h02);
    check("wr_byte_256th", wr_log[wb + 10'd255], 8'hFF);
    check("wr_byte_257th", wr_log[wb + 10'd256], 8'h00);
    check("wr_only_rxerr", rxerr, 0);
    ntxe = 1'b1;

    // both sides requesting: read first, then strict alternation, never overlapping
    reset = 1'b1;
    nrxf  = 1'b0;
    ntxe  = 1'b0;
    cyc(2);
    rb = rd_count;
    for (int k = 0; k < 16; k++) rx_seq[rb + 4'(k)] = 8'h40 + 8'(k);
    ob  = op_count;
    ov0 = overlap;
    reset = 1'b0;
    w = 0;
    while (op_count != ob + 8'd4 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("alt_ops_seen", op_count, ob + 8'd4);
    check("alt_op0_read", op_log[ob], 0);
    check("alt_op1_write", op_log[ob + 8'd1], 1);
    check("alt_op2_read", op_log[ob + 8'd2], 0);
    check("alt_op3_write", op_log[ob + 8'd3], 1);
    cyc(40);
    check("alt_no_overlap", overlap, ov0);
    check("alt_rxerr", rxerr, 0);

    // stall detection with STALL_LIMIT = 100
    reset = 1'b1;
    nrxf  = 1'b1;
    ntxe  = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(5);
    ntxe = 1'b1;
    cyc(99);
    ntxe = 1'b0;
    cyc(10);
    check("stall_99_no_err", txerr, 0);
    ntxe = 1'b1;
    cyc(100);
    ntxe = 1'b0;
    cyc(5);
    check("stall_100_err", txerr, 1);
    cyc(20);
    check("stall_err_sticky", txerr, 1);

    // reset during a write strobe aborts it and restarts the tx byte at 0x00
    wait_level(1, 1'b0, ok);
    check("abort_strobe_seen", ok, 1);
    reset = 1'b1;
    cyc(1);
    check("abort_nwd_high", nwd, 1);
    check("abort_bus_hiz", bus, 8'hFF);
    check("abort_txerr_clear", txerr, 0);
    check("abort_rxerr_clear", rxerr, 0);
    cyc(1);
    wb = wr_count;
    reset = 1'b0;
    wait_writes(wb + 10'd1, 100, ok);
    check("abort_next_write_done", ok, 1);
    check("abort_next_byte", wr_log[wb], 8'h00);
    ntxe = 1'b1;
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
